// File: rtl/wb_bridge_pkg.sv
// Shared types and bus widths for the core-to-Wishbone bridge.
package wb_bridge_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] dat;
        logic [SEL_W-1:0]  sel;
        logic              ins;
    } req_t;
endpackage

// File: rtl/wb_timeout.sv
// Bus-cycle watchdog: expired is high during the TIMEOUT-th enabled cycle after clear.
module wb_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)       cnt_d = '0;
        else if (enable) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // TIMEOUT of 0 never expires.
    assign expired = (TIMEOUT > 0) && enable && (cnt_q == LAST);
endmodule

// File: rtl/wb_bridge.sv
// Single-outstanding bridge from the core's valid/ready request port to Wishbone classic.
module wb_bridge
    import wb_bridge_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ext_valid,
    input  logic              ext_instruction,
    output logic              ext_ready,
    input  logic [ADDR_W-1:0] ext_address,
    input  logic [DATA_W-1:0] ext_write_data,
    input  logic [SEL_W-1:0]  ext_write_strobe,
    output logic [DATA_W-1:0] ext_read_data,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic [SEL_W-1:0]  wb_sel_o,
    output logic              wb_tgc_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    output logic              bus_error
);
    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              berr_q, berr_d;
    logic              expired;

    wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == IDLE && ext_valid),
        .enable  (state_q == BUS),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            berr_q  <= berr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        berr_d  = 1'b0;
        case (state_q)
            IDLE: if (ext_valid) begin
                req_d   = '{adr: ext_address, dat: ext_write_data,
                            sel: ext_write_strobe, ins: ext_instruction};
                state_d = BUS;
            end
            // err wins over ack; a timeout only fires when neither arrived.
            BUS: if (wb_err_i || (!wb_ack_i && expired)) begin
                rdata_d = '0;
                berr_d  = 1'b1;
                state_d = RESP;
            end else if (wb_ack_i) begin
                rdata_d = wb_dat_i;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign wb_cyc_o      = (state_q == BUS);
    assign wb_stb_o      = wb_cyc_o;
    assign wb_we_o       = wb_cyc_o && (|req_q.sel);
    assign wb_sel_o      = !wb_cyc_o ? '0 : ((|req_q.sel) ? req_q.sel : '1);
    assign wb_adr_o      = req_q.adr;
    assign wb_dat_o      = req_q.dat;
    assign wb_tgc_o      = req_q.ins;
    assign ext_ready     = (state_q == RESP);
    assign ext_read_data = rdata_q;
    assign bus_error     = berr_q;
endmodule

// File: doc/wb_bridge.md
WB_BRIDGE -- requirements
Module: wb_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: bus cycles to wait for ack/err before forced termination; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port ext_valid, input, 1: core request present; tied high by the core.
REQ-005 SHALL have port ext_instruction, input, 1: request is an instruction fetch.
REQ-006 SHALL have port ext_ready, output, 1: one-cycle response strobe to the core.
REQ-007 SHALL have port ext_address, input, 32: word-aligned request address.
REQ-008 SHALL have port ext_write_data, input, 32: store data.
REQ-009 SHALL have port ext_write_strobe, input, 4: byte enables; 0 means read.
REQ-010 SHALL have port ext_read_data, output, 32: response data, valid while ext_ready is high.
REQ-011 SHALL have ports wb_cyc_o and wb_stb_o, output, 1 each: Wishbone classic cycle and strobe.
REQ-012 SHALL have port wb_we_o, output, 1: Wishbone write enable.
REQ-013 SHALL have port wb_adr_o, output, 32: Wishbone address.
REQ-014 SHALL have ports wb_dat_o, output, 32, and wb_sel_o, output, 4: write data and byte select.
REQ-015 SHALL have port wb_tgc_o, output, 1: cycle tag, 1 = instruction fetch.
REQ-016 SHALL have ports wb_dat_i, input, 32; wb_ack_i, input, 1; wb_err_i, input, 1.
REQ-017 SHALL have port bus_error, output, 1: one-cycle pulse on err or timeout termination.

Function
REQ-018 SHALL implement the states IDLE, BUS and RESP.
REQ-019 In IDLE with ext_valid=1: latch address, write data, strobe and instruction flag into registers; go to BUS.
REQ-020 In BUS: wb_cyc_o=wb_stb_o=1; wb_adr_o, wb_dat_o, wb_tgc_o driven from the latched registers only, never combinationally from ext_*.
REQ-021 In BUS: wb_we_o = OR of latched strobe; wb_sel_o = latched strobe if writing, else 4'b1111.
REQ-022 In BUS on wb_ack_i=1: capture wb_dat_i into the response register, drop cyc/stb the next cycle, go to RESP.
REQ-023 In BUS on wb_err_i=1 (priority over ack when both are high): response data = 0, pulse bus_error, go to RESP.
REQ-024 With TIMEOUT>0, a cycle counter cleared on entry to BUS SHALL terminate when it reaches TIMEOUT with no ack/err: data 0, bus_error pulse, go to RESP.
REQ-025 In RESP: ext_ready=1 for exactly one cycle, ext_read_data = response register; go to IDLE.
REQ-026 ext_ready SHALL be 0 in IDLE and BUS; ext_read_data SHALL hold its last value outside RESP.
REQ-027 Latency SHALL be: request seen in cycle N, cyc/stb high from N+1, ack in cycle M, ext_ready in M+1; minimum 3 cycles, back-to-back throughput one access per 3 cycles.
REQ-028 Changes on ext_* during BUS/RESP SHALL be ignored; the next request is sampled only in IDLE.
REQ-029 An ack arriving after a timeout termination SHALL be ignored (cyc already low).

Reset
REQ-030 Reset SHALL force IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_sel_o=0, wb_adr_o=0, wb_dat_o=0, wb_tgc_o=0, ext_ready=0, ext_read_data=0, bus_error=0, counter=0.
REQ-031 Reset asserted mid-BUS SHALL drop cyc/stb in the next cycle with no ext_ready or bus_error pulse; the first request after deassertion is sampled normally.

Structure
REQ-032 Shared package SHALL hold the state enum (IDLE/BUS/RESP) and the bus width constants (32 address/data, 4 select).
REQ-033 The timeout counter SHALL be a sub-module wb_timeout (inputs clear, enable; output expired; parameter TIMEOUT).

Verification
REQ-034 Read: addr 0x0000_1004, strobe 0, ack with 0xDEAD_BEEF in the 2nd BUS cycle -> wb_we_o=0, wb_sel_o=4'hF, ext_ready one cycle later with 0xDEAD_BEEF.
REQ-035 Write: addr 0x0000_2000, data 0x1122_3344, strobe 4'b1100 -> wb_we_o=1, wb_sel_o=4'b1100, wb_dat_o=0x1122_3344, ext_ready after ack, bus_error=0.
REQ-036 Error: wb_err_i and wb_ack_i high together -> ext_read_data=0, bus_error one pulse, ext_ready one pulse.
REQ-037 Timeout: TIMEOUT=4, no ack -> cyc drops after 4 BUS cycles, ext_ready with data 0, bus_error pulse; a late ack causes no effect.
REQ-038 Reset mid-BUS -> cyc/stb low the next cycle, no ext_ready; a new fetch (ext_instruction=1) afterwards sets wb_tgc_o=1 and completes normally.
REQ-039 Back-to-back: 3 reads with ack in the first BUS cycle -> ext_ready at cycles 3, 6, 9, each returning its own ack data.
